// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit scheduler: slot record, FSM
// state encoding and the LFSR / spawn placement constants.
package fruit_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int VY_MAX   = 15;
  localparam int X_MARGIN = 32;
  localparam int X_SPAN   = 576;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    MOVE,
    SLICE
  } sched_state_t;

  typedef struct packed {
    logic              active;
    logic [1:0]        kind;
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic signed [3:0]  vx;
    logic signed [5:0]  vy;
  } fruit_slot_t;

endpackage

// File: rtl/fruit_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per cycle while advance is high;
// supplies spawn position, velocity and sprite kind.
module fruit_lfsr16
  import fruit_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        advance,
  output logic [15:0] value
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) value <= LFSR_SEED;
    else if (advance) value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/fruit_scheduler.sv
// Fruit pool scheduler: per-frame spawn/move sweep plus slice scan over NUM_SLOTS slots.
// Optional macro FRUIT_BOMB_EN makes kind 3 a bomb and adds the bomb_hit output.
module fruit_scheduler
  import fruit_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int FRUIT_SIZE   = 16,
  parameter int SPAWN_PERIOD = 60,
  parameter int GRAVITY      = 1,
  parameter int LAUNCH_VY    = 12
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic                   slice_valid,
  input  logic [9:0]             slice_x,
  input  logic [9:0]             slice_y,
  output logic                   slice_ready,
  output logic [NUM_SLOTS-1:0]   fruit_active,
  output logic [NUM_SLOTS*10-1:0] fruit_x,
  output logic [NUM_SLOTS*10-1:0] fruit_y,
  output logic [NUM_SLOTS*2-1:0] fruit_kind,
  output logic                   score_inc,
  output logic                   miss_inc,
  output logic                   overrun
`ifdef FRUIT_BOMB_EN
  ,
  output logic                   bomb_hit
`endif
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  SPAWN_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic signed [11:0] X_MAX     = 12'(SCREEN_W - FRUIT_SIZE);
  localparam logic signed [11:0] Y_OUT     = 12'(SCREEN_H);
  localparam logic signed [11:0] SIZE      = 12'(FRUIT_SIZE);
  localparam logic signed [6:0]  VY_CAP    = 7'(VY_MAX);
  localparam logic [5:0]         VY_CAP6   = 6'(VY_MAX);
  localparam logic signed [6:0]  GRAV      = 7'(GRAVITY);
  localparam logic [5:0]         VY_LAUNCH = 6'(-LAUNCH_VY);
  localparam logic [10:0]        Y_SPAWN   = 11'(SCREEN_H - FRUIT_SIZE);
  localparam logic [10:0]        X_BASE    = 11'(X_MARGIN);
  localparam logic [9:0]         SPAN      = 10'(X_SPAN);

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] spawn_cnt;
  logic             pending_frame;
  logic             armed;
  logic [9:0]       slice_xq, slice_yq;
  fruit_slot_t      slots [NUM_SLOTS];

  logic [15:0] lfsr;
  logic        lfsr_advance;
  logic        lfsr_unused;

  assign lfsr_advance = (state == SPAWN);
  assign lfsr_unused  = lfsr[13];

  fruit_lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .advance (lfsr_advance),
    .value   (lfsr)
  );

  // Ready is withheld for the first cycle out of reset so reset shows all outputs low.
  assign slice_ready = armed && (state == IDLE) && !pending_frame && !frame_tick;

  fruit_slot_t        cur, moved, spawn_slot;
  logic signed [11:0] ext_x, ext_y, mv_x, mv_y, sx, sy;
  logic signed [6:0]  mv_vy;
  logic [9:0]         span_off;
  logic               fall_out, hit, free_found;
  logic [IDX_W-1:0]   free_idx;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cur   = slots[idx];
    moved = cur;
    ext_x = $signed({cur.x[10], cur.x});
    ext_y = $signed({cur.y[10], cur.y});
    mv_x  = ext_x + $signed({{8{cur.vx[3]}}, cur.vx});
    mv_y  = ext_y + $signed({{6{cur.vy[5]}}, cur.vy});
    mv_vy = $signed({cur.vy[5], cur.vy}) + GRAV;

    moved.y  = mv_y[10:0];
    moved.vy = (mv_vy > VY_CAP) ? VY_CAP6 : mv_vy[5:0];
    if (mv_x[11]) begin
      moved.x  = '0;
      moved.vx = -cur.vx;
    end else if (mv_x > X_MAX) begin
      moved.x  = X_MAX[10:0];
      moved.vx = -cur.vx;
    end else begin
      moved.x = mv_x[10:0];
    end
    fall_out = !moved.vy[5] && (moved.vy != '0) && (mv_y >= Y_OUT);
    if (fall_out) moved.active = 1'b0;

    sx  = $signed({2'b00, slice_xq});
    sy  = $signed({2'b00, slice_yq});
    hit = cur.active && (sx >= ext_x) && (sx < ext_x + SIZE)
                     && (sy >= ext_y) && (sy < ext_y + SIZE);

    span_off          = (lfsr[9:0] >= SPAN) ? lfsr[9:0] - SPAN : lfsr[9:0];
    spawn_slot        = '0;
    spawn_slot.active = 1'b1;
    spawn_slot.x      = X_BASE + {1'b0, span_off};
    spawn_slot.y      = Y_SPAWN;
    spawn_slot.vx     = (lfsr[12:10] == 3'd7) ? 4'd3 : {1'b0, lfsr[12:10]} - 4'd3;
    spawn_slot.vy     = VY_LAUNCH;
`ifdef FRUIT_BOMB_EN
    spawn_slot.kind   = lfsr[15:14];
`else
    spawn_slot.kind   = (lfsr[15:14] == 2'd3) ? 2'd0 : lfsr[15:14];
`endif

    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      spawn_cnt     <= '0;
      pending_frame <= 1'b0;
      overrun       <= 1'b0;
      score_inc     <= 1'b0;
      miss_inc      <= 1'b0;
      armed         <= 1'b0;
      slice_xq      <= '0;
      slice_yq      <= '0;
`ifdef FRUIT_BOMB_EN
      bomb_hit      <= 1'b0;
`endif
      // NOTE: the slot array is a few flops, not a RAM, so it takes the async reset too.
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      score_inc <= 1'b0;
      miss_inc  <= 1'b0;
      armed     <= 1'b1;
`ifdef FRUIT_BOMB_EN
      bomb_hit  <= 1'b0;
`endif
      if (frame_tick && (state == SPAWN || state == MOVE)) overrun <= 1'b1;
      if (frame_tick && state == SLICE) pending_frame <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_tick || pending_frame) begin
            pending_frame <= 1'b0;
            if (enable) state <= SPAWN;
          end else if (slice_valid && slice_ready) begin
            slice_xq <= slice_x;
            slice_yq <= slice_y;
            idx      <= '0;
            state    <= SLICE;
          end
        end
        SPAWN: begin
          // A full pool holds the counter at its last value so the spawn retries every frame.
          if (spawn_cnt == SPAWN_LAST) begin
            if (free_found) begin
              slots[free_idx] <= spawn_slot;
              spawn_cnt       <= '0;
            end
          end else begin
            spawn_cnt <= spawn_cnt + 1'b1;
          end
          idx   <= '0;
          state <= MOVE;
        end
        MOVE: begin
          if (cur.active) begin
            slots[idx] <= moved;
            if (fall_out) miss_inc <= 1'b1;
          end
          if (idx == LAST_IDX) state <= IDLE;
          else idx <= idx + 1'b1;
        end
        SLICE: begin
          if (hit) begin
`ifdef FRUIT_BOMB_EN
            if (cur.kind == 2'd3) begin
              for (int i = 0; i < NUM_SLOTS; i++) slots[i].active <= 1'b0;
              bomb_hit <= 1'b1;
            end else begin
              slots[idx].active <= 1'b0;
              score_inc         <= 1'b1;
            end
`else
            slots[idx].active <= 1'b0;
            score_inc         <= 1'b1;
`endif
            state <= IDLE;
          end else if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fruit_active <= '0;
      fruit_x      <= '0;
      fruit_y      <= '0;
      fruit_kind   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        fruit_active[i]        <= slots[i].active;
        fruit_x[10*i +: 10]    <= slots[i].x[9:0];
        fruit_y[10*i +: 10]    <= slots[i].y[9:0];
        fruit_kind[2*i +: 2]   <= slots[i].kind;
      end
    end
  end

endmodule
